univ_shift_reg: RTL and testbench

//  Parametrised universal shift register for the pushbutton/LED datapath. It

---
 rtl/univ_shift_reg.sv | 159 +++++++++++++++
 tb/tb_univ_shift_reg.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: shift/rotate/ASR/load/clear, single-step or counted
// multi-step runs with busy/done, serial out and a saturating fill counter.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              AW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             d,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    fill,
    output logic             full
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [2:0] M_HOLD  = 3'd0;
    localparam logic [2:0] M_SHL   = 3'd1;
    localparam logic [2:0] M_SHR   = 3'd2;
    localparam logic [2:0] M_ROL   = 3'd3;
    localparam logic [2:0] M_ROR   = 3'd4;
    localparam logic [2:0] M_ASR   = 3'd5;
    localparam logic [2:0] M_LOAD  = 3'd6;
    localparam logic [2:0] M_CLEAR = 3'd7;

    localparam logic [AW-1:0] W_MAX = AW'(WIDTH);

    state_t           r_state, w_state_nxt;
    logic [AW-1:0]    r_cnt, w_cnt_nxt;
    logic [AW-1:0]    r_fill, w_fill_nxt, w_fill_inc;
    logic [AW-1:0]    w_amt_clamp;
    logic [2:0]       r_mode, w_mode_nxt, w_step_mode;
    logic [WIDTH-1:0] r_out, w_out_nxt;
    logic             r_sout, w_sout_nxt;
    logic             r_done, w_done_nxt;
    logic             w_do_step, w_degen;

    assign w_amt_clamp = (amt > W_MAX) ? W_MAX : amt;
    assign w_fill_inc  = (r_fill == W_MAX) ? r_fill : r_fill + AW'(1);

    // Zero-length runs and non-shifting modes complete in IDLE.
    assign w_degen = (amt == '0) || (mode == M_HOLD) ||
                     (mode == M_LOAD) || (mode == M_CLEAR);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_done_nxt  = 1'b0;
        w_do_step   = 1'b0;
        w_step_mode = mode;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_degen) begin
                        w_done_nxt = 1'b1;
                        w_do_step  = (mode == M_LOAD) ||
                                     (mode == M_CLEAR);
                    end else begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = w_amt_clamp;
                        w_mode_nxt  = mode;
                    end
                end else begin
                    w_do_step = en;
                end
            end
            S_RUN: begin
                w_step_mode = r_mode;
                w_do_step   = 1'b1;
                w_cnt_nxt   = r_cnt - AW'(1);
                if (r_cnt == AW'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_out_nxt  = r_out;
        w_sout_nxt = r_sout;
        w_fill_nxt = r_fill;
        if (w_do_step) begin
            unique case (w_step_mode)
                M_HOLD: ;
                M_SHL: begin
                    w_out_nxt  = {r_out[WIDTH-2:0], d};
                    w_sout_nxt = r_out[WIDTH-1];
                    w_fill_nxt = w_fill_inc;
                end
                M_SHR: begin
                    w_out_nxt  = {d, r_out[WIDTH-1:1]};
                    w_sout_nxt = r_out[0];
                    w_fill_nxt = w_fill_inc;
                end
                M_ROL: begin
                    w_out_nxt  = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
                    w_sout_nxt = r_out[WIDTH-1];
                end
                M_ROR: begin
                    w_out_nxt  = {r_out[0], r_out[WIDTH-1:1]};
                    w_sout_nxt = r_out[0];
                end
                M_ASR: begin
                    w_out_nxt  = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
                    w_sout_nxt = r_out[0];
                end
                M_LOAD: begin
                    w_out_nxt  = load_val;
                    w_fill_nxt = W_MAX;
                end
                M_CLEAR: begin
                    w_out_nxt  = '0;
                    w_fill_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mode  <= M_HOLD;
            r_out   <= RESET_VAL;
            r_sout  <= 1'b0;
            r_done  <= 1'b0;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_out   <= w_out_nxt;
            r_sout  <= w_sout_nxt;
            r_done  <= w_done_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

    assign out  = r_out;
    assign sout = r_sout;
    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign fill = r_fill;
    assign full = (r_fill == W_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8, RESET_VAL=0).
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rstn, en, d, start;
    logic [2:0] mode;
    logic [7:0] load_val, out;
    logic [3:0] amt, fill;
    logic       sout, busy, done, full;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] o;
        logic       s;
        logic [3:0] f;
    } exp_t;

    exp_t q[$];
    exp_t e;

    logic [7:0] m_out;
    logic       m_sout;
    logic [3:0] m_fill;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .d(d),
        .load_val(load_val), .start(start), .amt(amt),
        .out(out), .sout(sout), .busy(busy), .done(done),
        .fill(fill), .full(full)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [2:0] md, input logic di,
                                  input logic [7:0] lv);
        logic [7:0] t;
        logic [7:0] dv;
        t  = m_out;
        dv = {7'd0, di};
        case (md)
            3'd1: begin
                m_sout = t[7];
                m_out  = (t << 1) | dv;
                if (m_fill < 4'd8) m_fill = m_fill + 4'd1;
            end
            3'd2: begin
                m_sout = t[0];
                m_out  = (t >> 1) | (dv << 7);
                if (m_fill < 4'd8) m_fill = m_fill + 4'd1;
            end
            3'd3: begin m_sout = t[7]; m_out = (t << 1) | (t >> 7); end
            3'd4: begin m_sout = t[0]; m_out = (t >> 1) | (t << 7); end
            3'd5: begin m_sout = t[0]; m_out = 8'($signed(t) >>> 1); end
            3'd6: begin m_out = lv; m_fill = 4'd8; end
            3'd7: begin m_out = 8'h00; m_fill = 4'd0; end
            default: ;
        endcase
    endfunction

    task automatic drive_step(input logic [2:0] md, input logic di,
                              input logic [7:0] lv);
        @(negedge clk);
        en = 1'b1; mode = md; d = di; load_val = lv;
        model(md, di, lv);
        q.push_back('{m_out, m_sout, m_fill});
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] md, input logic [3:0] a,
                          input logic di, input bit pulse,
                          output int nb, output int lat,
                          output int dlen, output bit ovl);
        int steps;
        @(negedge clk);
        start = 1'b1; mode = md; amt = a; d = di; en = 1'b0;
        steps = (a > 4'd8) ? 8 : int'(a);
        if (md == 3'd6 || md == 3'd7) model(md, di, load_val);
        else if (md != 3'd0) repeat (steps) model(md, di, load_val);
        q.push_back('{m_out, m_sout, m_fill});
        @(negedge clk);
        start = 1'b0; mode = 3'd1; amt = 4'd2;
        nb = 0; lat = -1; dlen = 0; ovl = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            en = 1'b0;
            if (busy) nb++;
            if (busy && done) ovl = 1'b1;
            if (done) begin lat = c - 1; break; end
            if (pulse && busy) en = c[0];
            @(negedge clk);
        end
        en = 1'b0;
        if (lat >= 0) begin
            @(negedge clk);
            dlen = done ? 2 : 1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b0; start = 1'b0; d = 1'b0;
        mode = 3'd0; amt = 4'd0; load_val = 8'h00;
        m_out = 8'h00; m_sout = 1'b0; m_fill = 4'd0;
        repeat (2) @(negedge clk);
        total++;
        if ({out, sout, fill, full} !== 14'd0) begin
            bad++;
            $display("FAIL reset_state got=%h want=0", {out, sout, fill, full});
        end
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ctrl got busy/done=%b want 00", {busy, done});
        end
        rstn = 1'b1;
    endtask

    task automatic test_load();
        drive_step(3'd6, 1'b0, 8'hA5);
        e = q.pop_front();
        total++;
        if ({out, sout, fill} !== e) begin
            bad++;
            $display("FAIL load got=%h want=%h", {out, sout, fill}, e);
        end
        total++;
        if (full !== 1'b1) begin
            bad++;
            $display("FAIL load_full got=%b want=1", full);
        end
    endtask

    task automatic test_rol_busy();
        int nb, lat, dl;
        bit ov;
        run_op(3'd3, 4'd3, 1'b1, 1'b1, nb, lat, dl, ov);
        e = q.pop_front();
        total++;
        if ({out, sout, fill} !== e || e.o !== 8'h2D) begin
            bad++;
            $display("FAIL rol3 got=%h want=%h", {out, sout, fill}, e);
        end
        total++;
        if (nb != 3 || lat != 3) begin
            bad++;
            $display("FAIL rol3_busy got busy=%0d lat=%0d want 3/3", nb, lat);
        end
        total++;
        if (dl != 1 || ov) begin
            bad++;
            $display("FAIL rol3_done got len=%0d ovl=%0b want 1/0", dl, ov);
        end
    endtask

    task automatic test_asr();
        int nb, lat, dl;
        bit ov;
        drive_step(3'd6, 1'b0, 8'h90);
        e = q.pop_front();
        run_op(3'd5, 4'd2, 1'b0, 1'b0, nb, lat, dl, ov);
        e = q.pop_front();
        total++;
        if ({out, sout, fill} !== e || e.o !== 8'hE4) begin
            bad++;
            $display("FAIL asr2 got=%h want=%h", {out, sout, fill}, e);
        end
        total++;
        if (nb != 2 || lat != 2 || dl != 1) begin
            bad++;
            $display("FAIL asr2_ctrl got busy=%0d lat=%0d len=%0d want 2/2/1",
                     nb, lat, dl);
        end
    endtask

    task automatic test_shl_fill();
        drive_step(3'd7, 1'b0, 8'h00);
        e = q.pop_front();
        total++;
        if ({out, sout, fill} !== e) begin
            bad++;
            $display("FAIL clear got=%h want=%h", {out, sout, fill}, e);
        end
        for (int i = 0; i < 13; i++) begin
            drive_step(3'd1, 1'b1, 8'h00);
            e = q.pop_front();
            total++;
            if ({out, sout, fill} !== e) begin
                bad++;
                $display("FAIL shl_%0d got=%h want=%h", i, {out, sout, fill}, e);
            end
            if (i == 2) begin
                total++;
                if (out !== 8'h07 || full !== 1'b0) begin
                    bad++;
                    $display("FAIL shl3 got out=%h full=%b want 07/0", out, full);
                end
            end
        end
        total++;
        if (out !== 8'hFF || fill !== 4'd8 || full !== 1'b1) begin
            bad++;
            $display("FAIL shl_sat got out=%h fill=%0d full=%b want FF/8/1",
                     out, fill, full);
        end
    endtask

    task automatic test_amt0();
        int nb, lat, dl;
        bit ov;
        drive_step(3'd6, 1'b0, 8'h3C);
        e = q.pop_front();
        run_op(3'd1, 4'd0, 1'b1, 1'b0, nb, lat, dl, ov);
        e = q.pop_front();
        total++;
        if ({out, sout, fill} !== e || out !== 8'h3C) begin
            bad++;
            $display("FAIL amt0 got=%h want=%h", {out, sout, fill}, e);
        end
        total++;
        if (nb != 0 || lat != 0 || dl != 1) begin
            bad++;
            $display("FAIL amt0_ctrl got busy=%0d lat=%0d len=%0d want 0/0/1",
                     nb, lat, dl);
        end
    endtask

    task automatic test_clamp();
        int nb, lat, dl;
        bit ov;
        run_op(3'd4, 4'd15, 1'b0, 1'b0, nb, lat, dl, ov);
        e = q.pop_front();
        total++;
        if ({out, sout, fill} !== e) begin
            bad++;
            $display("FAIL clamp got=%h want=%h", {out, sout, fill}, e);
        end
        total++;
        if (nb != 8 || lat != 8 || ov) begin
            bad++;
            $display("FAIL clamp_ctrl got busy=%0d lat=%0d want 8/8", nb, lat);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        start = 1'b1; mode = 3'd2; amt = 4'd8; d = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy got=%b want=1", busy);
        end
        rstn = 1'b0;
        #1;
        m_out = 8'h00; m_sout = 1'b0; m_fill = 4'd0;
        q.delete();
        total++;
        if ({out, busy, fill, done} !== 14'd0) begin
            bad++;
            $display("FAIL mid_reset got out=%h busy=%b fill=%0d want 00/0/0",
                     out, busy, fill);
        end
        @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL mid_nodone got done/busy seen=1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_rol_busy();
        test_asr();
        test_shl_fill();
        test_amt0();
        test_clamp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
